// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants and types for the instruction fetch front end
package fetch_pkg;
    localparam int INSTR_W  = 32;
    localparam int OPCODE_W = 6;
    localparam int OPC_LSB  = 26;
    localparam int PC_STEP  = 4;
    localparam int PC_W     = 32;
    typedef enum logic [1:0] {S_FETCH, S_WAIT, S_DRAIN} fetch_state_t;
    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pc;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: small synchronous FIFO with flush and a registered head
module fetch_fifo #(
    parameter int W     = 64,
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  din,
    output logic [CW-1:0] count,
    output logic [W-1:0]  head
);
    localparam int PW = $clog2(DEPTH);
    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            rd_ptr <= wr_ptr;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end
    assign head = mem[rd_ptr];
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC register, req/ack fetch FSM and prefetch FIFO feeding decode
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int            AW       = 32,
    parameter int            DEPTH    = 2,
    parameter logic [AW-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst,
    output logic                imem_req,
    output logic [AW-1:0]       imem_addr,
    input  logic                imem_ack,
    input  logic [INSTR_W-1:0]  imem_rdata,
    input  logic                pc_src,
    input  logic [AW-1:0]       branch_target,
    output logic                dec_valid,
    input  logic                dec_ready,
    output logic [INSTR_W-1:0]  dec_instr,
    output logic [OPCODE_W-1:0] dec_opcode,
    output logic [AW-1:0]       dec_pc
);
    localparam int CW = $clog2(DEPTH) + 1;
    fetch_state_t         state_q, state_d;
    logic [AW-1:0]        pc_q, pc_d, addr_q;
    logic                 run_q, outstanding, push, pop;
    logic [CW-1:0]        count;
    logic [INSTR_W+AW-1:0] head;
    // run_q keeps imem_req low for the first cycle after reset
    always_comb begin
        outstanding = state_q != S_FETCH;
        imem_req    = run_q && (outstanding || count < CW'(DEPTH));
        imem_addr   = (state_q == S_DRAIN) ? addr_q : pc_q;
        push        = imem_req && imem_ack && !pc_src && state_q != S_DRAIN;
        pop         = dec_valid && dec_ready;
        pc_d        = pc_src ? branch_target : push ? pc_q + AW'(PC_STEP) : pc_q;
        state_d     = (imem_req && !imem_ack)
                    ? ((pc_src || state_q == S_DRAIN) ? S_DRAIN : S_WAIT) : S_FETCH;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_PC;
            addr_q  <= '0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= imem_addr;
            run_q   <= 1'b1;
        end
    end
    fetch_fifo #(.W(INSTR_W + AW), .DEPTH(DEPTH), .CW(CW)) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .flush(pc_src),
        .push (push),
        .pop  (pop),
        .din  ({imem_rdata, imem_addr}),
        .count(count),
        .head (head)
    );
    assign dec_valid  = count != '0;
    assign dec_instr  = head[AW +: INSTR_W];
    assign dec_pc     = head[AW-1:0];
    assign dec_opcode = dec_instr[OPC_LSB +: OPCODE_W];
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed checks of fetch, buffering, redirect, wrap and reset
module tb_instr_fetch_unit;
    logic        clk = 1'b0, rst = 1'b1;
    logic        imem_req, imem_ack, pc_src = 1'b0, dec_valid, dec_ready = 1'b1;
    logic [31:0] imem_addr, imem_rdata, branch_target = '0, dec_instr, dec_pc;
    logic [5:0]  dec_opcode;
    logic        ack_auto = 1'b1, ack_man = 1'b0;
    logic        w_req, w_valid;
    logic [31:0] w_addr, w_instr, w_pc;
    logic [5:0]  w_opc;
    int checks = 0, failures = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] word(input logic [31:0] a);
        return {a[7:2] ^ 6'h2A, a[25:0] + 26'h123456};
    endfunction

    assign imem_ack   = ack_auto ? imem_req : ack_man;
    assign imem_rdata = word(imem_addr);

    instr_fetch_unit dut (
        .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .pc_src(pc_src),
        .branch_target(branch_target), .dec_valid(dec_valid), .dec_ready(dec_ready),
        .dec_instr(dec_instr), .dec_opcode(dec_opcode), .dec_pc(dec_pc)
    );

    instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clk(clk), .rst(rst), .imem_req(w_req), .imem_addr(w_addr),
        .imem_ack(w_req), .imem_rdata(32'h0), .pc_src(1'b0),
        .branch_target(32'h0), .dec_valid(w_valid), .dec_ready(1'b1),
        .dec_instr(w_instr), .dec_opcode(w_opc), .dec_pc(w_pc)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    initial begin
        // reset state
        step();
        step();
        chk("rst_req", 64'(imem_req), 64'd0);
        chk("rst_valid", 64'(dec_valid), 64'd0);
        chk("rst_instr", 64'(dec_instr), 64'd0);
        chk("rst_opcode", 64'(dec_opcode), 64'd0);
        chk("rst_pc", 64'(dec_pc), 64'd0);
        rst = 1'b0;
        step();
        chk("first_req", 64'(imem_req), 64'd1);
        chk("first_addr", 64'(imem_addr), 64'd0);
        chk("wrap_addr0", 64'(w_addr), 64'hFFFF_FFFC);
        // streaming with zero-latency memory
        step();
        chk("wrap_addr1", 64'(w_addr), 64'h0);
        chk("wrap_decpc", 64'(w_pc), 64'hFFFF_FFFC);
        for (int i = 0; i < 4; i++) begin
            chk("s1_valid", 64'(dec_valid), 64'd1);
            chk("s1_pc", 64'(dec_pc), 64'(4 * i));
            chk("s1_instr", 64'(dec_instr), 64'(word(32'(4 * i))));
            chk("s1_opc", 64'(dec_opcode), 64'((6'(i) ^ 6'h2A)));
            chk("s1_addr", 64'(imem_addr), 64'(4 * (i + 1)));
            step();
        end
        // backpressure fills FIFO to DEPTH
        dec_ready = 1'b0;
        do_reset();
        step();
        step();
        chk("s2_req_full", 64'(imem_req), 64'd0);
        chk("s2_head", 64'(dec_pc), 64'd0);
        step();
        chk("s2_hold_req", 64'(imem_req), 64'd0);
        chk("s2_hold_pc", 64'(dec_pc), 64'd0);
        dec_ready = 1'b1;
        step();
        chk("s2_pc4", 64'(dec_pc), 64'd4);
        chk("s2_instr4", 64'(dec_instr), 64'(word(32'd4)));
        chk("s2_req_again", 64'(imem_req), 64'd1);
        chk("s2_addr8", 64'(imem_addr), 64'd8);
        step();
        chk("s2_pc8", 64'(dec_pc), 64'd8);
        // redirect while waiting on slow memory
        ack_auto = 1'b0;
        ack_man  = 1'b0;
        do_reset();
        step();
        step();
        chk("s3_wait_addr", 64'(imem_addr), 64'd0);
        pc_src = 1'b1;
        branch_target = 32'h40;
        step();
        pc_src = 1'b0;
        chk("s3_drain_req", 64'(imem_req), 64'd1);
        chk("s3_drain_addr", 64'(imem_addr), 64'd0);
        chk("s3_drain_valid", 64'(dec_valid), 64'd0);
        ack_man = 1'b1;
        step();
        ack_man = 1'b0;
        chk("s3_dropped", 64'(dec_valid), 64'd0);
        chk("s3_new_addr", 64'(imem_addr), 64'h40);
        chk("s3_new_req", 64'(imem_req), 64'd1);
        ack_man = 1'b1;
        step();
        ack_man = 1'b0;
        chk("s3_valid", 64'(dec_valid), 64'd1);
        chk("s3_pc", 64'(dec_pc), 64'h40);
        chk("s3_instr", 64'(dec_instr), 64'(word(32'h40)));
        // redirect with simultaneous pop on full FIFO
        ack_auto  = 1'b1;
        dec_ready = 1'b0;
        do_reset();
        step();
        step();
        dec_ready = 1'b1;
        pc_src = 1'b1;
        branch_target = 32'h80;
        chk("s4_popped_valid", 64'(dec_valid), 64'd1);
        chk("s4_popped_pc", 64'(dec_pc), 64'd0);
        step();
        pc_src = 1'b0;
        chk("s4_flushed", 64'(dec_valid), 64'd0);
        chk("s4_addr", 64'(imem_addr), 64'h80);
        step();
        chk("s4_valid", 64'(dec_valid), 64'd1);
        chk("s4_pc", 64'(dec_pc), 64'h80);
        // reset during an outstanding request, then a late ack
        ack_auto = 1'b0;
        ack_man  = 1'b0;
        do_reset();
        step();
        rst = 1'b1;
        step();
        chk("s6_req", 64'(imem_req), 64'd0);
        chk("s6_valid", 64'(dec_valid), 64'd0);
        ack_man = 1'b1;
        step();
        rst = 1'b0;
        step();
        chk("s6_late_ack", 64'(dec_valid), 64'd0);
        chk("s6_req_again", 64'(imem_req), 64'd1);
        chk("s6_addr", 64'(imem_addr), 64'd0);
        ack_man = 1'b0;
        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
